// File: rtl/combat_resolver.sv
// Per-frame combat resolution: connect test, block/hit, damage, stun timers and KO latch.
// Every output is registered; inputs sampled on a frame edge affect outputs right after it.
module combat_resolver #(
    parameter logic [9:0] SPRITE_W    = 10'd64,
    parameter logic [9:0] REACH_N     = 10'd32,
    parameter logic [9:0] REACH_D     = 10'd48,
    parameter logic [2:0] HEALTH_INIT = 3'd3,
    parameter logic [2:0] DMG_N       = 3'd1,
    parameter logic [2:0] DMG_D       = 3'd2,
    parameter logic [4:0] HITSTUN_N   = 5'd20,
    parameter logic [4:0] BLOCKSTUN_N = 5'd12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] p1_x,
    input  logic [9:0] p2_x,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic       p1_dir_atk,
    input  logic       p2_dir_atk,
    output logic [2:0] p1_health,
    output logic [2:0] p2_health,
    output logic       p1_hitstun,
    output logic       p2_hitstun,
    output logic       p1_blockstun,
    output logic       p2_blockstun,
    output logic       p1_hit_evt,
    output logic       p2_hit_evt,
    output logic       p1_blk_evt,
    output logic       p2_blk_evt,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [3:0] ST_MOVE_BWD   = 4'd2;
    localparam logic [3:0] ST_ATTACK_ACT = 4'd6;

    logic [2:0]  p1_health_q, p1_health_d, p2_health_q, p2_health_d;
    logic [4:0]  p1_hs_cnt_q, p1_hs_cnt_d, p2_hs_cnt_q, p2_hs_cnt_d;
    logic [4:0]  p1_bs_cnt_q, p1_bs_cnt_d, p2_bs_cnt_q, p2_bs_cnt_d;
    logic        p1_hitstun_q, p2_hitstun_q, p1_blockstun_q, p2_blockstun_q;
    logic        p1_hit_evt_q, p2_hit_evt_q, p1_blk_evt_q, p2_blk_evt_q;
    logic        p1_consumed_q, p1_consumed_d, p2_consumed_q, p2_consumed_d;
    logic        game_over_q, game_over_d;
    logic [1:0]  winner_q, winner_d;

    logic [10:0] p1_reach, p2_reach, p1_edge, p2_edge;
    logic        p1_in_range, p2_in_range;
    logic        p1_conn_raw, p2_conn_raw, p1_conn, p2_conn;
    logic        hit_on_p1, hit_on_p2, blk_on_p1, blk_on_p2;
    logic        ko;

    function automatic logic [4:0] stun_next(input logic load, input logic clear,
                                             input logic [4:0] cnt, input logic [4:0] load_val);
        logic [4:0] nxt;
        if (load) begin
            nxt = load_val;
        end else if (clear || cnt == 5'd0) begin
            nxt = 5'd0;
        end else begin
            nxt = cnt - 5'd1;
        end
        return nxt;
    endfunction

    function automatic logic [2:0] sat_sub(input logic [2:0] h, input logic [2:0] dmg);
        return (h > dmg) ? h - dmg : 3'd0;
    endfunction

    always_comb begin
        // Both attackers test the same gap; only the reach depends on who swings.
        p1_reach    = p1_dir_atk ? {1'b0, REACH_D} : {1'b0, REACH_N};
        p2_reach    = p2_dir_atk ? {1'b0, REACH_D} : {1'b0, REACH_N};
        p1_edge     = {1'b0, p1_x} + {1'b0, SPRITE_W} + p1_reach;
        p2_edge     = {1'b0, p1_x} + {1'b0, SPRITE_W} + p2_reach;
        p1_in_range = {1'b0, p2_x} < p1_edge;
        p2_in_range = {1'b0, p2_x} < p2_edge;

        p1_conn_raw = (p1_state == ST_ATTACK_ACT) && !p1_consumed_q && p1_in_range;
        p2_conn_raw = (p2_state == ST_ATTACK_ACT) && !p2_consumed_q && p2_in_range;
        p1_conn     = p1_conn_raw && !game_over_q;
        p2_conn     = p2_conn_raw && !game_over_q;

        p1_consumed_d = (p1_state == ST_ATTACK_ACT) && (p1_consumed_q || p1_conn_raw);
        p2_consumed_d = (p2_state == ST_ATTACK_ACT) && (p2_consumed_q || p2_conn_raw);

        blk_on_p2 = p1_conn && (p2_state == ST_MOVE_BWD);
        hit_on_p2 = p1_conn && (p2_state != ST_MOVE_BWD);
        blk_on_p1 = p2_conn && (p1_state == ST_MOVE_BWD);
        hit_on_p1 = p2_conn && (p1_state != ST_MOVE_BWD);

        p1_health_d = hit_on_p1 ? sat_sub(p1_health_q, p2_dir_atk ? DMG_D : DMG_N)
                                : p1_health_q;
        p2_health_d = hit_on_p2 ? sat_sub(p2_health_q, p1_dir_atk ? DMG_D : DMG_N)
                                : p2_health_q;

        p1_hs_cnt_d = stun_next(hit_on_p1, blk_on_p1, p1_hs_cnt_q, HITSTUN_N);
        p1_bs_cnt_d = stun_next(blk_on_p1, hit_on_p1, p1_bs_cnt_q, BLOCKSTUN_N);
        p2_hs_cnt_d = stun_next(hit_on_p2, blk_on_p2, p2_hs_cnt_q, HITSTUN_N);
        p2_bs_cnt_d = stun_next(blk_on_p2, hit_on_p2, p2_bs_cnt_q, BLOCKSTUN_N);

        // Winner bits are {p1 dead, p2 dead}: 01 = P1 survives, 10 = P2, 11 = draw.
        ko          = !game_over_q && (p1_health_d == 3'd0 || p2_health_d == 3'd0);
        game_over_d = game_over_q || ko;
        winner_d    = ko ? {p1_health_d == 3'd0, p2_health_d == 3'd0} : winner_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_health_q    <= HEALTH_INIT;
            p2_health_q    <= HEALTH_INIT;
            p1_hs_cnt_q    <= 5'd0;
            p2_hs_cnt_q    <= 5'd0;
            p1_bs_cnt_q    <= 5'd0;
            p2_bs_cnt_q    <= 5'd0;
            p1_hitstun_q   <= 1'b0;
            p2_hitstun_q   <= 1'b0;
            p1_blockstun_q <= 1'b0;
            p2_blockstun_q <= 1'b0;
            p1_hit_evt_q   <= 1'b0;
            p2_hit_evt_q   <= 1'b0;
            p1_blk_evt_q   <= 1'b0;
            p2_blk_evt_q   <= 1'b0;
            p1_consumed_q  <= 1'b0;
            p2_consumed_q  <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 2'b00;
        end else begin
            p1_health_q    <= p1_health_d;
            p2_health_q    <= p2_health_d;
            p1_hs_cnt_q    <= p1_hs_cnt_d;
            p2_hs_cnt_q    <= p2_hs_cnt_d;
            p1_bs_cnt_q    <= p1_bs_cnt_d;
            p2_bs_cnt_q    <= p2_bs_cnt_d;
            p1_hitstun_q   <= (p1_hs_cnt_d != 5'd0);
            p2_hitstun_q   <= (p2_hs_cnt_d != 5'd0);
            p1_blockstun_q <= (p1_bs_cnt_d != 5'd0);
            p2_blockstun_q <= (p2_bs_cnt_d != 5'd0);
            p1_hit_evt_q   <= hit_on_p1;
            p2_hit_evt_q   <= hit_on_p2;
            p1_blk_evt_q   <= blk_on_p1;
            p2_blk_evt_q   <= blk_on_p2;
            p1_consumed_q  <= p1_consumed_d;
            p2_consumed_q  <= p2_consumed_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
        end
    end

    assign p1_health    = p1_health_q;
    assign p2_health    = p2_health_q;
    assign p1_hitstun   = p1_hitstun_q;
    assign p2_hitstun   = p2_hitstun_q;
    assign p1_blockstun = p1_blockstun_q;
    assign p2_blockstun = p2_blockstun_q;
    assign p1_hit_evt   = p1_hit_evt_q;
    assign p2_hit_evt   = p2_hit_evt_q;
    assign p1_blk_evt   = p1_blk_evt_q;
    assign p2_blk_evt   = p2_blk_evt_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Bench for combat_resolver: fixed vector table, timing corner sequences and random
// play compared every frame against a frame-count based reference model.
module tb_combat_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] p1_x, p2_x;
    logic [3:0] p1_state, p2_state;
    logic       p1_dir_atk, p2_dir_atk;
    logic [2:0] p1_health, p2_health;
    logic       p1_hitstun, p2_hitstun, p1_blockstun, p2_blockstun;
    logic       p1_hit_evt, p2_hit_evt, p1_blk_evt, p2_blk_evt;
    logic       game_over;
    logic [1:0] winner;

    combat_resolver dut (
        .clk          (clk),
        .reset        (reset),
        .p1_x         (p1_x),
        .p2_x         (p2_x),
        .p1_state     (p1_state),
        .p2_state     (p2_state),
        .p1_dir_atk   (p1_dir_atk),
        .p2_dir_atk   (p2_dir_atk),
        .p1_health    (p1_health),
        .p2_health    (p2_health),
        .p1_hitstun   (p1_hitstun),
        .p2_hitstun   (p2_hitstun),
        .p1_blockstun (p1_blockstun),
        .p2_blockstun (p2_blockstun),
        .p1_hit_evt   (p1_hit_evt),
        .p2_hit_evt   (p2_hit_evt),
        .p1_blk_evt   (p1_blk_evt),
        .p2_blk_evt   (p2_blk_evt),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: stun is tracked as "frame at which it expires" instead of a counter.
    int frame;
    int m_h[2];
    int m_hs_end[2];
    int m_bs_end[2];
    int m_cons[2];
    int m_hit_evt[2];
    int m_blk_evt[2];
    int m_go;
    int m_win;

    typedef struct {
        int rst;
        int x1, x2, s1, s2, d1, d2;
        int h1, h2, hit1, hit2, blk1, blk2, go, win;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame = 0;
        m_go  = 0;
        m_win = 0;
        for (int i = 0; i < 2; i++) begin
            m_h[i]       = 3;
            m_hs_end[i]  = 0;
            m_bs_end[i]  = 0;
            m_cons[i]    = 0;
            m_hit_evt[i] = 0;
            m_blk_evt[i] = 0;
        end
    endtask

    task automatic model_step();
        int st[2];
        int dir[2];
        int conn[2];
        int gap_ok;
        st[0]  = int'(p1_state);
        st[1]  = int'(p2_state);
        dir[0] = int'(p1_dir_atk);
        dir[1] = int'(p2_dir_atk);
        frame++;
        for (int a = 0; a < 2; a++) begin
            gap_ok  = (int'(p2_x) < int'(p1_x) + 64 + (dir[a] != 0 ? 48 : 32)) ? 1 : 0;
            conn[a] = (m_go == 0 && st[a] == 6 && m_cons[a] == 0 && gap_ok == 1) ? 1 : 0;
        end
        for (int a = 0; a < 2; a++) begin
            int d;
            d = 1 - a;
            m_cons[a]    = (st[a] == 6 && (m_cons[a] != 0 || conn[a] != 0)) ? 1 : 0;
            m_hit_evt[d] = 0;
            m_blk_evt[d] = 0;
            if (conn[a] != 0) begin
                if (st[d] == 2) begin
                    m_blk_evt[d] = 1;
                    m_bs_end[d]  = frame + 12;
                    m_hs_end[d]  = frame;
                end else begin
                    m_hit_evt[d] = 1;
                    m_h[d]       = m_h[d] - (dir[a] != 0 ? 2 : 1);
                    if (m_h[d] < 0) m_h[d] = 0;
                    m_hs_end[d]  = frame + 20;
                    m_bs_end[d]  = frame;
                end
            end
        end
        if (m_go == 0 && (m_h[0] == 0 || m_h[1] == 0)) begin
            m_go  = 1;
            m_win = (m_h[0] == 0 ? 2 : 0) + (m_h[1] == 0 ? 1 : 0);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " p1_health"},    int'(p1_health),    m_h[0]);
        chk({tag, " p2_health"},    int'(p2_health),    m_h[1]);
        chk({tag, " p1_hitstun"},   int'(p1_hitstun),   frame < m_hs_end[0] ? 1 : 0);
        chk({tag, " p2_hitstun"},   int'(p2_hitstun),   frame < m_hs_end[1] ? 1 : 0);
        chk({tag, " p1_blockstun"}, int'(p1_blockstun), frame < m_bs_end[0] ? 1 : 0);
        chk({tag, " p2_blockstun"}, int'(p2_blockstun), frame < m_bs_end[1] ? 1 : 0);
        chk({tag, " p1_hit_evt"},   int'(p1_hit_evt),   m_hit_evt[0]);
        chk({tag, " p2_hit_evt"},   int'(p2_hit_evt),   m_hit_evt[1]);
        chk({tag, " p1_blk_evt"},   int'(p1_blk_evt),   m_blk_evt[0]);
        chk({tag, " p2_blk_evt"},   int'(p2_blk_evt),   m_blk_evt[1]);
        chk({tag, " game_over"},    int'(game_over),    m_go);
        chk({tag, " winner"},       int'(winner),       m_win);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input int x1, input int x2, input int s1, input int s2,
                        input int d1, input int d2, input string tag);
        p1_x       = 10'(x1);
        p2_x       = 10'(x2);
        p1_state   = 4'(s1);
        p2_state   = 4'(s2);
        p1_dir_atk = 1'(d1);
        p2_dir_atk = 1'(d2);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Asynchronous: outputs must already be at reset values 1 time unit after assertion.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int cnt_stun;
        int cnt_evt;
        int k;

        reset = 1'b0;
        p1_x = 10'd10; p2_x = 10'd200; p1_state = 4'd0; p2_state = 4'd0;
        p1_dir_atk = 1'b0; p2_dir_atk = 1'b0;
        model_reset();
        #2;
        do_reset("init_reset");

        //           rst  x1   x2  s1 s2 d1 d2   h1 h2 hit1 hit2 blk1 blk2 go win
        vecs[0]  = '{1, 10, 100, 6, 0, 0, 0,  3, 2, 0, 1, 0, 0, 0, 0};
        vecs[1]  = '{0, 10, 100, 6, 0, 0, 0,  3, 2, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 10, 100, 0, 0, 0, 0,  3, 2, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 10, 100, 6, 0, 0, 0,  3, 1, 0, 1, 0, 0, 0, 0};
        vecs[4]  = '{0, 10, 106, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 10, 106, 6, 0, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{1, 10, 122, 6, 0, 1, 0,  3, 3, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 10, 120, 0, 0, 0, 0,  3, 3, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 10, 120, 6, 0, 1, 0,  3, 1, 0, 1, 0, 0, 0, 0};
        vecs[9]  = '{0, 10, 120, 0, 2, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 10, 120, 6, 2, 1, 0,  3, 1, 0, 0, 0, 1, 0, 0};
        vecs[11] = '{0, 10, 120, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 10, 120, 0, 6, 0, 1,  1, 1, 1, 0, 0, 0, 0, 0};
        vecs[13] = '{0, 10, 120, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{0, 10, 120, 6, 6, 1, 1,  0, 0, 1, 1, 0, 0, 1, 3};
        vecs[15] = '{0, 10, 120, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 3};
        vecs[16] = '{0, 10, 120, 6, 6, 1, 1,  0, 0, 0, 0, 0, 0, 1, 3};
        vecs[17] = '{1, 10, 100, 0, 6, 0, 1,  1, 3, 1, 0, 0, 0, 0, 0};
        vecs[18] = '{0, 10, 100, 0, 0, 0, 0,  1, 3, 0, 0, 0, 0, 0, 0};
        vecs[19] = '{0, 10, 100, 0, 6, 0, 1,  0, 3, 1, 0, 0, 0, 1, 2};

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].rst != 0) do_reset($sformatf("vec%0d_reset", i));
            step(vecs[i].x1, vecs[i].x2, vecs[i].s1, vecs[i].s2, vecs[i].d1, vecs[i].d2,
                 $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl p1_health", i), int'(p1_health),  vecs[i].h1);
            chk($sformatf("vec%0d tbl p2_health", i), int'(p2_health),  vecs[i].h2);
            chk($sformatf("vec%0d tbl p1_hit_evt", i), int'(p1_hit_evt), vecs[i].hit1);
            chk($sformatf("vec%0d tbl p2_hit_evt", i), int'(p2_hit_evt), vecs[i].hit2);
            chk($sformatf("vec%0d tbl p1_blk_evt", i), int'(p1_blk_evt), vecs[i].blk1);
            chk($sformatf("vec%0d tbl p2_blk_evt", i), int'(p2_blk_evt), vecs[i].blk2);
            chk($sformatf("vec%0d tbl game_over", i), int'(game_over),  vecs[i].go);
            chk($sformatf("vec%0d tbl winner", i),    int'(winner),     vecs[i].win);
        end

        // Hitstun width and single-cycle hit pulse.
        do_reset("hs_reset");
        step(10, 100, 6, 0, 0, 0, "hs_hit");
        cnt_stun = int'(p2_hitstun);
        cnt_evt  = int'(p2_hit_evt);
        k = 0;
        while (p2_hitstun && k < 40) begin
            step(10, 100, 0, 0, 0, 0, "hs_idle");
            cnt_stun += int'(p2_hitstun);
            cnt_evt  += int'(p2_hit_evt);
            k++;
        end
        chk("hitstun_len", cnt_stun, 20);
        chk("hit_evt_width", cnt_evt, 1);

        // Blockstun width; hitstun stays low and health untouched.
        do_reset("bs_reset");
        step(10, 100, 6, 2, 0, 0, "bs_blk");
        cnt_stun = int'(p2_blockstun);
        k = 0;
        while (p2_blockstun && k < 40) begin
            step(10, 100, 0, 0, 0, 0, "bs_idle");
            cnt_stun += int'(p2_blockstun);
            k++;
        end
        chk("blockstun_len", cnt_stun, 12);
        chk("blk_health", int'(p2_health), 3);

        // Combo: second hit 5 frames into hitstun restarts the full 20 frames.
        do_reset("combo_reset");
        step(10, 100, 6, 0, 0, 0, "combo_hit1");
        for (int i = 0; i < 5; i++) step(10, 100, 0, 0, 0, 0, "combo_gap");
        step(10, 100, 6, 0, 0, 0, "combo_hit2");
        cnt_stun = 1;
        k = 0;
        while (p2_hitstun && k < 40) begin
            step(10, 100, 0, 0, 0, 0, "combo_idle");
            cnt_stun += int'(p2_hitstun);
            k++;
        end
        chk("combo_hitstun_len", cnt_stun, 20);
        chk("combo_health", int'(p2_health), 1);

        // Reset while the hitstun counter sits at 10.
        do_reset("mid_reset0");
        step(10, 100, 6, 0, 0, 0, "mid_hit");
        for (int i = 0; i < 10; i++) step(10, 100, 6, 0, 0, 0, "mid_hold");
        chk("mid_hitstun_before", int'(p2_hitstun), 1);
        do_reset("mid_reset");
        chk("mid_reset_health", int'(p2_health), 3);

        // Random play against the model.
        for (int i = 0; i < 3000; i++) begin
            int x1, x2, s1, s2, r1, r2;
            if ($urandom_range(0, 99) < 3) do_reset("rnd_reset");
            x1 = int'($urandom_range(0, 400));
            x2 = x1 + int'($urandom_range(64, 150));
            r1 = int'($urandom_range(0, 9));
            r2 = int'($urandom_range(0, 9));
            s1 = (r1 < 4) ? 6 : (r1 < 6) ? 2 : int'($urandom_range(0, 15));
            s2 = (r2 < 4) ? 6 : (r2 < 6) ? 2 : int'($urandom_range(0, 15));
            step(x1, x2, s1, s2, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/combat_resolver.md
# combat_resolver

Per-frame hit resolution stage directly downstream of the two player movement/attack FSMs. Each 60 Hz frame it samples both players' positions, FSM state codes and attack-type flags, decides whether an active attack connects, and applies blocking, damage, hitstun/blockstun timers and KO detection. Its stun outputs feed back to the player FSMs, and its health, event and winner outputs drive the HUD and game-flow logic.

## Interface
- SPRITE_W, 10'd64, sprite width in px; also the FSMs' minimum x separation
- REACH_N, 10'd32, hitbox reach beyond sprite edge for a neutral attack
- REACH_D, 10'd48, hitbox reach for a directional attack
- HEALTH_INIT, 3'd3, health loaded at reset
- DMG_N, 3'd1, damage from a neutral attack
- DMG_D, 3'd2, damage from a directional attack
- HITSTUN_N, 5'd20, hitstun frames
- BLOCKSTUN_N, 5'd12, blockstun frames
- clk  in  1  60 Hz frame clock, shared with the player FSMs
- reset  in  1  asynchronous, active-high
- p1_x, p2_x  in  10 each  sprite left-edge x; P1 is always left of P2
- p1_state, p2_state  in  4 each  FSM state codes (2 = MOVE_BWD, 6 = ATTACK_ACT)
- p1_dir_atk, p2_dir_atk  in  1 each  high = current attack is directional
- p1_health, p2_health  out  3 each  remaining health
- p1_hitstun, p2_hitstun  out  1 each  player is in hitstun
- p1_blockstun, p2_blockstun  out  1 each  player is in blockstun
- p1_hit_evt, p2_hit_evt  out  1 each  one-cycle pulse: this player took a hit
- p1_blk_evt, p2_blk_evt  out  1 each  one-cycle pulse: this player blocked
- game_over  out  1  sticky KO flag
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

## Operation
- Reset values: health = HEALTH_INIT; all stun flags, event pulses and game_over = 0; winner = 00; stun counters and consumed latches = 0.
- Connect test for attacker A on defender D: A_state == 6, A's consumed latch is clear, and p2_x < p1_x + SPRITE_W + reach, with reach = REACH_D if A_dir_atk else REACH_N. Evaluate in 11-bit unsigned arithmetic; the sum cannot wrap.
- Consumed latch per attacker: set on a connect, cleared on any cycle where that attacker's state != 6. Each attack connects at most once, even across multiple ACT frames.
- Block: on a connect, if D_state == 2, the hit is blocked.
  - Health is unchanged.
  - D's blockstun counter loads BLOCKSTUN_N and D's hitstun counter clears.
  - D_blk_evt pulses.
- Hit: on an unblocked connect:
  - D_health decreases by DMG_N or DMG_D, saturating at 0.
  - D's hitstun counter loads HITSTUN_N and D's blockstun counter clears.
  - D_hit_evt pulses.
- A connect during existing stun reloads that stun counter (combo); damage still applies.
- Trade: both players connect in the same frame, so both take the full effect. Neither can block, because both are in state 6.
- Stun counters are 5-bit. Each decrements by 1 per cycle while nonzero. Stun flag = (counter != 0), registered.
- KO: when any health becomes 0, game_over sets and winner is latched. Winner is the survivor, or 11 if both hit 0 in the same frame.
- After game_over: connects are ignored (no damage, no events), stun counters keep running down, health frozen. Only reset clears game_over.

## Timing
- All outputs are registered. Inputs are sampled at edge N; the resulting health, stun flag and event pulse appear after edge N, i.e. 1 cycle latency.
- Event pulses are high for exactly 1 cycle.
- Stun flag is high for exactly HITSTUN_N (or BLOCKSTUN_N) cycles after the connect edge, absent a reload.
- game_over and winner update on the same edge as the lethal health update.
- Reset asserted mid-stun or mid-attack returns all outputs to reset values immediately (asynchronous).

## Test plan
- Range: p1_x = 10, p2_x = 100, p1_state = 6 for one cycle, neutral. Gap 26 < 32, so next cycle p2_health = 2, p2_hit_evt = 1 for 1 cycle, p2_hitstun high for exactly 20 cycles. Repeat with p2_x = 106 → no hit.
- Directional reach and damage: p2_x = 120, p1_dir_atk = 1. Gap 46 < 48, so p2_health 3 → 1. p2_x = 122 → no hit.
- Block: p2_state = 2 during a connect → p2_health unchanged, p2_blk_evt pulse, p2_blockstun high for 12 cycles, p2_hitstun = 0.
- Single connect per attack: p1_state = 6 for 2 consecutive cycles in range → exactly 1 damage and 1 pulse. Leave state 6, re-enter → a second hit lands.
- Trade and KO: both healths = 1, both states = 6 in range on the same cycle → both health 0, game_over = 1, winner = 11. A further connect changes nothing.
- Reset during hitstun (counter at 10) → all outputs return to reset values immediately; health = 3.
